// File: rtl/storage_cmd_master.sv
// rtl/storage_cmd_master.sv - request/response front end issuing single-cycle commands to a word storage
//
// Purpose:
//   Accepts one request at a time (RD, WR, ADD, SUB), presents it to the storage
//   for exactly one cycle, and for reads captures the registered storage output
//   and holds it until the consumer takes it. Outside the issue cycle the storage
//   sees a harmless read of address 0 with zero write data.
//
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_op                - 00 RD, 01 WR, 10 ADD, 11 SUB
//   req_addA/B/C          - operand A / read address, operand B, destination
//   req_wdata             - write data
//   cmd, addA/B/C, DQ_i   - command bus to the storage
//   DQ_o                  - registered read data from the storage
//   rsp_valid/rsp_ready   - read response handshake
//   rsp_data              - captured read data
//   busy                  - high whenever the FSM is not idle
//   op_count              - commands issued since reset, wraps at 16 bits

module storage_cmd_master #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [MEM_LENGTH-1:0] req_addA,
    input  logic [MEM_LENGTH-1:0] req_addB,
    input  logic [MEM_LENGTH-1:0] req_addC,
    input  logic [MEM_WIDTH-1:0]  req_wdata,
    output logic [1:0]            cmd,
    output logic [MEM_LENGTH-1:0] addA,
    output logic [MEM_LENGTH-1:0] addB,
    output logic [MEM_LENGTH-1:0] addC,
    output logic [MEM_WIDTH-1:0]  DQ_i,
    input  logic [MEM_WIDTH-1:0]  DQ_o,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_WIDTH-1:0]  rsp_data,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RD_CAP = 2'd2,
        S_RSP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_RD = 2'b00;

    state_t                r_state;
    state_t                w_next;

    logic [1:0]            r_op;
    logic [MEM_LENGTH-1:0] r_addA;
    logic [MEM_LENGTH-1:0] r_addB;
    logic [MEM_LENGTH-1:0] r_addC;
    logic [MEM_WIDTH-1:0]  r_wdata;
    logic [MEM_WIDTH-1:0]  r_rsp_data;
    logic [15:0]           r_op_count;

    logic                  w_accept;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // State register, request capture, counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_addA     <= '0;
            r_addB     <= '0;
            r_addC     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_op_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= req_op;
                r_addA  <= req_addA;
                r_addB  <= req_addB;
                r_addC  <= req_addC;
                r_wdata <= req_wdata;
            end
            // The command is consumed by the storage on the edge leaving ISSUE.
            if (r_state == S_ISSUE) begin
                r_op_count <= r_op_count + 16'd1;
            end
            // DQ_o here is the result of the RD presented in ISSUE; the idle RD
            // driven during RD_CAP only lands on DQ_o after this edge.
            if (r_state == S_RD_CAP) begin
                r_rsp_data <= DQ_o;
            end
        end
    end

    // Next state and outputs.
    always_comb begin
        w_next    = r_state;
        cmd       = 2'b00;
        addA      = '0;
        addB      = '0;
        addC      = '0;
        DQ_i      = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd  = r_op;
                addA = r_addA;
                addB = r_addB;
                addC = r_addC;
                DQ_i = r_wdata;
                w_next = (r_op == OP_RD) ? S_RD_CAP : S_IDLE;
            end
            S_RD_CAP: begin
                w_next = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign rsp_data = r_rsp_data;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_storage_cmd_master.sv
// tb/tb_storage_cmd_master.sv - directed self-checking bench for storage_cmd_master

module tb_storage_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_addA = 4'd0;
    logic [3:0]  req_addB = 4'd0;
    logic [3:0]  req_addC = 4'd0;
    logic [15:0] req_wdata = 16'd0;
    logic [1:0]  cmd;
    logic [3:0]  addA;
    logic [3:0]  addB;
    logic [3:0]  addC;
    logic [15:0] DQ_i;
    logic [15:0] DQ_o;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    storage_cmd_master #(.MEM_WIDTH(16), .MEM_LENGTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addA  (req_addA),
        .req_addB  (req_addB),
        .req_addC  (req_addC),
        .req_wdata (req_wdata),
        .cmd       (cmd),
        .addA      (addA),
        .addB      (addB),
        .addC      (addC),
        .DQ_i      (DQ_i),
        .DQ_o      (DQ_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Storage model: executes cmd on every rising edge, read data registered.
    logic [15:0] mem [0:15];
    always @(posedge clk) begin
        case (cmd)
            2'b00: DQ_o <= mem[addA];
            2'b01: mem[addC] <= DQ_i;
            2'b10: mem[addC] <= mem[addA] + mem[addB];
            2'b11: mem[addC] <= mem[addA] - mem[addB];
            default: ;
        endcase
    end

    // Presents a request from a falling edge and returns at the falling edge
    // of the ISSUE cycle, with req_valid already dropped.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [15:0] wd);
        int n;
        req_op = op; req_addA = a; req_addB = b; req_addC = c; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
    endtask

    // Issues a RD and returns the data plus the cycle (acceptance = 0) at which
    // rsp_valid first appeared; with rsp_ready high it returns in IDLE.
    task automatic do_read(input logic [3:0] a, output logic [15:0] data, output int lat);
        send(2'b00, a, 4'd0, 4'd0, 16'd0);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = rsp_data;
        if (rsp_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/valid/busy=%b required 100", {req_ready, rsp_valid, busy});
        end
        checks++;
        if (rsp_data !== 16'd0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: rsp_data=%h op_count=%h required 0000 0000", rsp_data, op_count);
        end
        checks++;
        if ({cmd, addA, addB, addC, DQ_i} !== 30'd0) begin
            errors++;
            $display("FAIL reset_idle_cmd: cmd=%b addA=%h addB=%h addC=%h DQ_i=%h required all 0",
                     cmd, addA, addB, addC, DQ_i);
        end
        rst = 1'b0;
        exp_cnt = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_wr_rd();
        logic [15:0] d;
        int lat;
        send(2'b01, 4'd0, 4'd0, 4'd3, 16'h00A5);
        checks++;
        if ({cmd, addC, DQ_i, busy, req_ready} !== {2'b01, 4'd3, 16'h00A5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wr_issue: cmd=%b addC=%h DQ_i=%h busy=%b ready=%b required 01 3 00a5 1 0",
                     cmd, addC, DQ_i, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || cmd !== 2'b00 || addC !== 4'd0) begin
            errors++;
            $display("FAIL wr_turnaround: ready=%b cmd=%b addC=%h required 1 00 0", req_ready, cmd, addC);
        end
        do_read(4'd3, d, lat);
        checks++;
        if (d !== 16'h00A5) begin
            errors++;
            $display("FAIL wr_rd_data: rsp_data=%h required 00a5", d);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL rd_latency: rsp_valid at cycle %0d required 3", lat);
        end
        checks++;
        if (req_ready !== 1'b1 || op_count !== 16'd2) begin
            errors++;
            $display("FAIL wr_rd_count: ready=%b op_count=%h required 1 0002", req_ready, op_count);
        end
    endtask

    task automatic test_add_wrap();
        logic [15:0] d;
        int lat;
        send(2'b01, 4'd0, 4'd0, 4'd1, 16'hFFFF);
        send(2'b01, 4'd0, 4'd0, 4'd2, 16'h0002);
        send(2'b10, 4'd1, 4'd2, 4'd4, 16'h0000);
        checks++;
        if ({cmd, addA, addB, addC} !== {2'b10, 4'd1, 4'd2, 4'd4}) begin
            errors++;
            $display("FAIL add_issue: cmd=%b A=%h B=%h C=%h required 10 1 2 4", cmd, addA, addB, addC);
        end
        @(negedge clk);
        do_read(4'd4, d, lat);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL add_wrap: rsp_data=%h required 0001", d);
        end
    endtask

    task automatic test_sub_underflow();
        logic [15:0] d;
        int lat;
        send(2'b01, 4'd0, 4'd0, 4'd5, 16'h0003);
        send(2'b01, 4'd0, 4'd0, 4'd6, 16'h0005);
        send(2'b11, 4'd5, 4'd6, 4'd7, 16'h0000);
        checks++;
        if ({cmd, addA, addB, addC} !== {2'b11, 4'd5, 4'd6, 4'd7}) begin
            errors++;
            $display("FAIL sub_issue: cmd=%b A=%h B=%h C=%h required 11 5 6 7", cmd, addA, addB, addC);
        end
        @(negedge clk);
        do_read(4'd7, d, lat);
        checks++;
        if (d !== 16'hFFFE) begin
            errors++;
            $display("FAIL sub_underflow: rsp_data=%h required fffe", d);
        end
    endtask

    task automatic test_same_addr();
        logic [15:0] d;
        int lat;
        send(2'b01, 4'd0, 4'd0, 4'd8, 16'h0003);
        send(2'b10, 4'd8, 4'd8, 4'd8, 16'h0000);
        checks++;
        if ({cmd, addA, addB, addC} !== {2'b10, 4'd8, 4'd8, 4'd8}) begin
            errors++;
            $display("FAIL same_addr_issue: cmd=%b A=%h B=%h C=%h required 10 8 8 8", cmd, addA, addB, addC);
        end
        @(negedge clk);
        do_read(4'd8, d, lat);
        checks++;
        if (d !== 16'h0006) begin
            errors++;
            $display("FAIL same_addr_data: rsp_data=%h required 0006", d);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        int lat;
        send(2'b01, 4'd0, 4'd0, 4'd0, 16'h1234);
        send(2'b01, 4'd0, 4'd0, 4'd9, 16'h0BAD);
        @(negedge clk);
        rsp_ready = 1'b0;
        do_read(4'd3, d, lat);
        checks++;
        if (d !== 16'h00A5 || lat !== 3) begin
            errors++;
            $display("FAIL bp_first: rsp_data=%h cycle=%0d required 00a5 3", d, lat);
        end
        for (int i = 0; i < 5; i++) begin
            // Activity on the request side must be ignored while not ready.
            req_valid = 1'b1; req_op = 2'b01; req_addC = 4'd9; req_wdata = 16'hDEA0 + 16'(i);
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready, cmd, addA, addC} !== {1'b1, 1'b0, 2'b00, 4'd0, 4'd0} ||
                rsp_data !== 16'h00A5) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b cmd=%b addA=%h addC=%h data=%h required 1 0 00 0 0 00a5",
                         i, rsp_valid, req_ready, cmd, addA, addC, rsp_data);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b op_count=%h required 1 0 %h",
                     req_ready, rsp_valid, op_count, exp_cnt);
        end
        do_read(4'd9, d, lat);
        checks++;
        if (d !== 16'h0BAD) begin
            errors++;
            $display("FAIL bp_ignored_req: mem[9]=%h required 0bad", d);
        end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        send(2'b00, 4'd3, 4'd0, 4'd0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'd0;
        checks++;
        if ({rsp_valid, req_ready, busy} !== 3'b010 || op_count !== 16'd0 || rsp_data !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_read: valid=%b ready=%b busy=%b op_count=%h data=%h required 0 1 0 0000 0000",
                     rsp_valid, req_ready, busy, op_count, rsp_data);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_no_response: rsp_valid seen %0d cycles required 0", seen);
        end
    endtask

    task automatic test_op_count_wrap();
        for (int i = 0; i < 65535; i++) begin
            send(2'b01, 4'd0, 4'd0, 4'd10, 16'(i));
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_ffff: op_count=%h required ffff", op_count);
        end
        send(2'b01, 4'd0, 4'd0, 4'd10, 16'h0000);
        @(negedge clk);
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap: op_count=%h required 0000", op_count);
        end
        send(2'b01, 4'd0, 4'd0, 4'd10, 16'h0001);
        @(negedge clk);
        checks++;
        if (op_count !== 16'h0001) begin
            errors++;
            $display("FAIL count_after_wrap: op_count=%h required 0001", op_count);
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_wr_rd();
        test_add_wrap();
        test_sub_underflow();
        test_same_addr();
        test_backpressure();
        test_reset_mid_read();
        test_op_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
